// File: rtl/pc_unit.sv
// pc_unit: parametrised program-counter unit.
//   Holds the fetch PC and advances it by INC while fetch is accepted.
//   It accepts trap, jump and branch redirects in that priority order.
//   A misaligned jump/branch target loads TRAP_VEC instead of the target.
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   halt                 enter HALTED at the next edge (in RUN)
//   fetch_ready          instruction memory accepts pc this cycle
//   fetch_valid          pc is a valid fetch address (RUN only)
//   pc                   registered fetch PC
//   pc_next_seq          pc + INC (combinational), the return address for jal
//   br_taken/br_target   branch redirect request and target
//   jmp_en/jmp_target    jump redirect request and target
//   trap                 trap request; also the only way out of HALTED
//   misalign_err         one-cycle pulse after a misaligned redirect
module pc_unit #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     INC       = 4,
    parameter int unsigned     ALIGN     = 2,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(8'hF0)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             jmp_en,
    input  logic [WIDTH-1:0] jmp_target,
    input  logic             trap,
    output logic             misalign_err
);

    // With ALIGN == 0 this mask is all zeros, so the alignment check never fires.
    localparam logic [WIDTH-1:0] AMASK = WIDTH'((64'd1 << ALIGN) - 64'd1);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             err_q, err_d;
    logic             redir;
    logic [WIDTH-1:0] tgt;

    assign pc_next_seq  = pc_q + WIDTH'(INC);
    assign pc           = pc_q;
    assign fetch_valid  = (state_q == RUN);
    assign misalign_err = err_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        err_d   = 1'b0;
        redir   = 1'b0;
        tgt     = '0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (trap) begin
                    pc_d = TRAP_VEC;
                end else if (jmp_en) begin
                    redir = 1'b1;
                    tgt   = jmp_target;
                end else if (br_taken) begin
                    redir = 1'b1;
                    tgt   = br_target;
                end else if (fetch_ready) begin
                    pc_d = pc_next_seq;
                end
                // Only the selected target is checked. A lower-priority
                // request that is masked in the same cycle is ignored.
                if (redir) begin
                    if ((tgt & AMASK) != '0) begin
                        pc_d  = TRAP_VEC;
                        err_d = 1'b1;
                    end else begin
                        pc_d = tgt;
                    end
                end
                if (halt) state_d = HALTED;
            end
            HALTED: begin
                if (trap) begin
                    pc_d    = TRAP_VEC;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst, halt, fetch_ready, br_taken, jmp_en, trap;
    logic [15:0] br_t, jmp_t;

    always #5 clk = ~clk;

    // Instance 0: defaults. 1: ALIGN=0. 2: WIDTH=16, INC=2, ALIGN=1.
    logic [7:0]  pc0, ns0, pc1, ns1;
    logic [15:0] pc2, ns2;
    logic        v0, v1, v2, e0, e1, e2;

    pc_unit u0 (
        .clk(clk), .rst(rst), .halt(halt), .fetch_ready(fetch_ready),
        .fetch_valid(v0), .pc(pc0), .pc_next_seq(ns0),
        .br_taken(br_taken), .br_target(br_t[7:0]),
        .jmp_en(jmp_en), .jmp_target(jmp_t[7:0]),
        .trap(trap), .misalign_err(e0)
    );

    pc_unit #(.ALIGN(0)) u1 (
        .clk(clk), .rst(rst), .halt(halt), .fetch_ready(fetch_ready),
        .fetch_valid(v1), .pc(pc1), .pc_next_seq(ns1),
        .br_taken(br_taken), .br_target(br_t[7:0]),
        .jmp_en(jmp_en), .jmp_target(jmp_t[7:0]),
        .trap(trap), .misalign_err(e1)
    );

    pc_unit #(.WIDTH(16), .INC(2), .ALIGN(1), .RESET_VEC(16'h0000), .TRAP_VEC(16'h00F0)) u2 (
        .clk(clk), .rst(rst), .halt(halt), .fetch_ready(fetch_ready),
        .fetch_valid(v2), .pc(pc2), .pc_next_seq(ns2),
        .br_taken(br_taken), .br_target(br_t),
        .jmp_en(jmp_en), .jmp_target(jmp_t),
        .trap(trap), .misalign_err(e2)
    );

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per-instance PC, mode and error flag.
    localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;
    int               pw[3] = '{8, 8, 16};
    int               pinc[3] = '{4, 4, 2};
    int               palign[3] = '{2, 0, 1};
    longint unsigned  ptrap[3] = '{64'hF0, 64'hF0, 64'hF0};
    longint unsigned  m_pc[3];
    int               m_mode[3];
    bit               m_err[3];
    bit               started = 0;

    task automatic model_step(input int k);
        longint unsigned modv = 64'd1 << pw[k];
        longint unsigned am   = 64'd1 << palign[k];
        longint unsigned t;
        bit              rd = 0;
        if (rst) begin
            m_pc[k] = 0; m_mode[k] = M_BOOT; m_err[k] = 0;
            return;
        end
        m_err[k] = 0;
        if (m_mode[k] == M_BOOT) begin
            m_mode[k] = M_RUN;
        end else if (m_mode[k] == M_HALT) begin
            if (trap) begin m_pc[k] = ptrap[k]; m_mode[k] = M_RUN; end
        end else begin
            if (trap)             m_pc[k] = ptrap[k];
            else if (jmp_en)      begin rd = 1; t = jmp_t % modv; end
            else if (br_taken)    begin rd = 1; t = br_t % modv; end
            else if (fetch_ready) m_pc[k] = (m_pc[k] + pinc[k]) % modv;
            if (rd) begin
                if (t % am != 0) begin m_pc[k] = ptrap[k]; m_err[k] = 1; end
                else m_pc[k] = t;
            end
            if (halt) m_mode[k] = M_HALT;
        end
    endtask

    always @(posedge clk) begin
        if (rst) started = 1;
        for (int k = 0; k < 3; k++) model_step(k);
    end

    // Compare every cycle once reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            chk("u0.pc", pc0, m_pc[0]);
            chk("u0.valid", v0, m_mode[0] == M_RUN);
            chk("u0.err", e0, m_err[0]);
            chk("u0.nseq", ns0, (m_pc[0] + 4) % 256);
            chk("u1.pc", pc1, m_pc[1]);
            chk("u1.valid", v1, m_mode[1] == M_RUN);
            chk("u1.err", e1, m_err[1]);
            chk("u1.nseq", ns1, (m_pc[1] + 4) % 256);
            chk("u2.pc", pc2, m_pc[2]);
            chk("u2.valid", v2, m_mode[2] == M_RUN);
            chk("u2.err", e2, m_err[2]);
            chk("u2.nseq", ns2, (m_pc[2] + 2) % 65536);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        rst = 0; halt = 0; fetch_ready = 0; br_taken = 0; jmp_en = 0; trap = 0;
        br_t = '0; jmp_t = '0;
    endtask

    initial begin
        clr();
        rst = 1; fetch_ready = 1;
        tick();
        chk("lit.reset_pc", pc0, 8'h00);
        chk("lit.reset_valid", v0, 0);
        chk("lit.reset_err", e0, 0);
        rst = 0;
        tick();
        chk("lit.boot_pc", pc0, 8'h00);
        chk("lit.run_valid", v0, 1);
        tick(); chk("lit.inc1", pc0, 8'h04);
        tick(); chk("lit.inc2", pc0, 8'h08);
        fetch_ready = 0;
        repeat (3) tick();
        chk("lit.stall", pc0, 8'h08);
        fetch_ready = 1;
        tick(); chk("lit.after_stall", pc0, 8'h0C);
        // jump beats branch; redirect ignores ready=0
        fetch_ready = 0; br_taken = 1; br_t = 16'h20; jmp_en = 1; jmp_t = 16'h40;
        tick(); chk("lit.jmp_over_br", pc0, 8'h40);
        trap = 1;
        tick(); chk("lit.trap_over_all", pc0, 8'hF0);
        clr();
        jmp_en = 1; jmp_t = 16'h41;
        tick();
        chk("lit.misalign_pc", pc0, 8'hF0);
        chk("lit.misalign_err", e0, 1);
        chk("lit.align0_pc", pc1, 8'h41);
        chk("lit.align0_err", e1, 0);
        clr();
        tick();
        chk("lit.err_pulse_end", e0, 0);
        // wrap
        jmp_en = 1; jmp_t = 16'hFC;
        tick(); chk("lit.at_fc", pc0, 8'hFC);
        clr(); fetch_ready = 1;
        tick();
        chk("lit.wrap8", pc0, 8'h00);
        chk("lit.wrap8_err", e0, 0);
        clr(); jmp_en = 1; jmp_t = 16'hFFFE;
        tick(); chk("lit.at_fffe", pc2, 16'hFFFE);
        clr(); fetch_ready = 1;
        tick(); chk("lit.wrap16", pc2, 16'h0000);
        // halt with stall freezes at 10
        clr(); jmp_en = 1; jmp_t = 16'h10;
        tick();
        clr(); halt = 1;
        tick();
        chk("lit.halt_pc", pc0, 8'h10);
        chk("lit.halt_valid", v0, 0);
        clr(); br_taken = 1; br_t = 16'h20; fetch_ready = 1;
        repeat (2) tick();
        chk("lit.halt_frozen", pc0, 8'h10);
        clr(); trap = 1;
        tick();
        chk("lit.trap_exit_pc", pc0, 8'hF0);
        chk("lit.trap_exit_valid", v0, 1);
        clr(); fetch_ready = 1;
        tick(); chk("lit.run_again", pc0, 8'hF4);
        // redirect with halt: the target loads, then the unit halts
        br_taken = 1; br_t = 16'h24; halt = 1;
        tick();
        chk("lit.halt_redir_pc", pc0, 8'h24);
        chk("lit.halt_redir_valid", v0, 0);
        clr(); trap = 1;
        tick();
        // lower-priority misaligned branch is not checked
        clr(); jmp_en = 1; jmp_t = 16'h40; br_taken = 1; br_t = 16'h21;
        tick();
        chk("lit.masked_br_pc", pc0, 8'h40);
        chk("lit.masked_br_err", e0, 0);
        clr(); br_taken = 1; br_t = 16'h22;
        tick();
        chk("lit.br_misalign_pc", pc0, 8'hF0);
        chk("lit.br_misalign_err", e0, 1);
        chk("lit.br_align1_pc", pc2, 16'h0022);
        clr(); fetch_ready = 1;
        tick();
        // reset mid-run
        rst = 1;
        tick();
        chk("lit.rst_mid_pc", pc0, 8'h00);
        chk("lit.rst_mid_valid", v0, 0);
        rst = 0;
        tick(); chk("lit.rst_boot_pc", pc0, 8'h00);
        tick(); chk("lit.rst_run_pc", pc0, 8'h04);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
